// File: rtl/sng_bitstream_gen_if.sv
// Stream-control and random-word handshake bundle for sng_bitstream_gen.
// With SNG_FULLSCALE_EN defined, prob widens to PW+1 bits so that 2^PW
// (certain 1) can be programmed.
interface sng_bitstream_gen_if #(
    parameter int WIDTH = 32,
    parameter int PW    = 16,
    parameter int LEN_W = 16
);
`ifdef SNG_FULLSCALE_EN
    localparam int PROB_W = PW + 1;
`else
    localparam int PROB_W = PW;
`endif

    logic              start;
    logic [PROB_W-1:0] prob;
    logic [LEN_W-1:0]  len;
    logic [WIDTH-1:0]  rnd_in;
    logic              rnd_valid;
    logic              rnd_ready;
    logic              bit_out;
    logic              bit_valid;
    logic [LEN_W-1:0]  ones_cnt;
    logic              busy;
    logic              done;

    modport master (
        output start, prob, len, rnd_in, rnd_valid,
        input  rnd_ready, bit_out, bit_valid, ones_cnt, busy, done
    );

    modport slave (
        input  start, prob, len, rnd_in, rnd_valid,
        output rnd_ready, bit_out, bit_valid, ones_cnt, busy, done
    );
endinterface

// File: rtl/sng_bitstream_gen.sv
// Stochastic number generator: turns uniform random words into a unipolar
// bitstream of programmed length, one word per bit, and counts the 1s.
// Optional feature macro: SNG_FULLSCALE_EN (prob is PW+1 bits, 2^PW = all ones).
//
// state | meaning
// IDLE  | waiting for start; ones_cnt holds result of last stream
// RUN   | consuming one random word per handshake, emitting one bit each
// DONE  | single-cycle completion pulse, then back to IDLE
module sng_bitstream_gen #(
    parameter int WIDTH = 32,
    parameter int PW    = 16,
    parameter int LEN_W = 16
) (
    input  logic clk,
    input  logic rst,
    sng_bitstream_gen_if.slave bus
);
`ifdef SNG_FULLSCALE_EN
    localparam int PROB_W = PW + 1;
`else
    localparam int PROB_W = PW;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [PROB_W-1:0] prob_q;
    logic [LEN_W-1:0]  bits_left;
    logic [LEN_W-1:0]  ones_q;
    logic              bit_q;
    logic              valid_q;
    logic              done_q;

    logic [PW-1:0]     rnd_top;
    logic              handshake;
    logic              bit_now;

    assign rnd_top   = bus.rnd_in[WIDTH-1 -: PW];
    assign handshake = (state == RUN) && bus.rnd_valid;

    // Unsigned strict compare; in the full-scale build the word is
    // zero-extended so prob >= 2^PW always yields 1.
`ifdef SNG_FULLSCALE_EN
    assign bit_now = ({1'b0, rnd_top} < prob_q);
`else
    assign bit_now = (rnd_top < prob_q);
`endif

    // Sequencer: bits_left is loaded with len and counts down to the last handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prob_q    <= '0;
            bits_left <= '0;
            ones_q    <= '0;
            bit_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        prob_q    <= bus.prob;
                        bits_left <= bus.len;
                        ones_q    <= '0;
                        if (bus.len != '0) begin
                            state <= RUN;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        bit_q     <= bit_now;
                        valid_q   <= 1'b1;
                        bits_left <= bits_left - LEN_W'(1);
                        if (bit_now) begin
                            ones_q <= ones_q + LEN_W'(1);
                        end
                        if (bits_left == LEN_W'(1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs: ready/busy decode the state register, everything else is registered.
    assign bus.rnd_ready = (state == RUN);
    assign bus.busy      = (state == RUN);
    assign bus.bit_out   = bit_q;
    assign bus.bit_valid = valid_q;
    assign bus.ones_cnt  = ones_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_sng_bitstream_gen.sv
// Self-checking bench for sng_bitstream_gen: scoreboard of expected bits,
// one task per scenario, taus88 software model for the soak stream.
module tb_sng_bitstream_gen;
    localparam int WIDTH = 32;
    localparam int PW    = 16;
    localparam int LEN_W = 16;
`ifdef SNG_FULLSCALE_EN
    localparam int PROB_W = PW + 1;
`else
    localparam int PROB_W = PW;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sng_bitstream_gen_if #(.WIDTH(WIDTH), .PW(PW), .LEN_W(LEN_W)) bus ();

    sng_bitstream_gen #(.WIDTH(WIDTH), .PW(PW), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard and reference model state
    bit                q_bits [$];
    logic [PROB_W-1:0] m_prob;
    int                m_left;
    bit                m_run;
    int                m_ones;
    bit                exp_valid;
    bit                exp_done;

    logic [31:0] s1, s2, s3;

    task automatic taus_step(output logic [31:0] r);
        logic [31:0] b;
        b  = ((s1 << 13) ^ s1) >> 19;
        s1 = ((s1 & 32'hFFFF_FFFE) << 12) ^ b;
        b  = ((s2 << 2) ^ s2) >> 25;
        s2 = ((s2 & 32'hFFFF_FFF8) << 4) ^ b;
        b  = ((s3 << 3) ^ s3) >> 11;
        s3 = ((s3 & 32'hFFFF_FFF0) << 17) ^ b;
        r  = s1 ^ s2 ^ s3;
    endtask

    // Pulse start for one edge and prime the model with the new stream.
    task automatic start_stream(input logic [PROB_W-1:0] p, input logic [LEN_W-1:0] l);
        bus.start     = 1'b1;
        bus.prob      = p;
        bus.len       = l;
        bus.rnd_valid = 1'b0;
        m_prob    = p;
        m_left    = int'(l);
        m_ones    = 0;
        m_run     = (l != '0);
        exp_valid = 1'b0;
        exp_done  = (l == '0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Present one word; push the predicted bit if the model expects a handshake.
    task automatic step(input bit v, input logic [WIDTH-1:0] w);
        bit b;
        bus.rnd_valid = v;
        bus.rnd_in    = w;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (m_run && v) begin
            b = (w[WIDTH-1 -: PW] < m_prob);
            q_bits.push_back(b);
            if (b) m_ones++;
            m_left--;
            exp_valid = 1'b1;
            if (m_left == 0) begin
                m_run    = 1'b0;
                exp_done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.prob = '0; bus.len = '0;
        bus.rnd_in = '0; bus.rnd_valid = 1'b0;
        m_run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.rnd_ready, bus.bit_out, bus.bit_valid, bus.busy, bus.done} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {bus.rnd_ready, bus.bit_out, bus.bit_valid, bus.busy, bus.done});
        end
        n_checks++;
        if (bus.ones_cnt !== '0) begin
            n_errors++;
            $display("FAIL reset_ones got %0d exp 0", bus.ones_cnt);
        end
        rst = 1'b0;
        // Words arriving in IDLE are dropped
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom);
            n_checks++;
            if (bus.bit_valid !== 1'b0 || bus.rnd_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_drop got valid=%b ready=%b exp 0 0", bus.bit_valid, bus.rnd_ready);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] tops [4];
        bit e;
        tops = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
        start_stream(PROB_W'(17'h08000), 16'd4);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.rnd_ready !== 1'b1 || bus.ones_cnt !== '0) begin
            n_errors++;
            $display("FAIL basic_start got busy=%b ready=%b ones=%0d exp 1 1 0",
                     bus.busy, bus.rnd_ready, bus.ones_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, {tops[i], 16'h5A5A});
            n_checks++;
            if (bus.bit_valid !== exp_valid) begin
                n_errors++;
                $display("FAIL basic_valid cyc%0d got %b exp %b", i, bus.bit_valid, exp_valid);
            end
            if (exp_valid) begin
                e = q_bits.pop_front();
                n_checks++;
                if (bus.bit_out !== e) begin
                    n_errors++;
                    $display("FAIL basic_bit cyc%0d got %b exp %b", i, bus.bit_out, e);
                end
            end
            n_checks++;
            if (bus.done !== exp_done) begin
                n_errors++;
                $display("FAIL basic_done cyc%0d got %b exp %b", i, bus.done, exp_done);
            end
        end
        n_checks++;
        if (bus.ones_cnt !== 16'd2 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_ones got %0d busy=%b exp 2 0", bus.ones_cnt, bus.busy);
        end
        repeat (3) step(1'b1, 32'h0);
        n_checks++;
        if (bus.ones_cnt !== 16'd2 || bus.done !== 1'b0 || bus.bit_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_hold got ones=%0d done=%b valid=%b exp 2 0 0",
                     bus.ones_cnt, bus.done, bus.bit_valid);
        end
    endtask

    task automatic test_len_zero();
        start_stream(PROB_W'(17'h0FFFF), 16'd0);
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.bit_valid !== 1'b0 || bus.ones_cnt !== '0) begin
            n_errors++;
            $display("FAIL len0_done got done=%b busy=%b valid=%b ones=%0d exp 1 0 0 0",
                     bus.done, bus.busy, bus.bit_valid, bus.ones_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.bit_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL len0_idle cyc%0d got done=%b busy=%b valid=%b exp 0 0 0",
                         i, bus.done, bus.busy, bus.bit_valid);
            end
        end
    endtask

    task automatic test_valid_gaps();
        bit pat [7];
        bit e;
        int pulses;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        pulses = 0;
        start_stream(PROB_W'(17'h08000), 16'd3);
        for (int i = 0; i < 7; i++) begin
            step(pat[i], $urandom);
            if (bus.bit_valid === 1'b1) pulses++;
            n_checks++;
            if (bus.bit_valid !== exp_valid) begin
                n_errors++;
                $display("FAIL gaps_valid cyc%0d got %b exp %b", i, bus.bit_valid, exp_valid);
            end
            if (exp_valid) begin
                e = q_bits.pop_front();
                n_checks++;
                if (bus.bit_out !== e) begin
                    n_errors++;
                    $display("FAIL gaps_bit cyc%0d got %b exp %b", i, bus.bit_out, e);
                end
            end
            n_checks++;
            if (bus.done !== exp_done) begin
                n_errors++;
                $display("FAIL gaps_done cyc%0d got %b exp %b", i, bus.done, exp_done);
            end
        end
        n_checks++;
        if (pulses != 3 || bus.ones_cnt !== 16'(m_ones)) begin
            n_errors++;
            $display("FAIL gaps_count got pulses=%0d ones=%0d exp 3 %0d", pulses, bus.ones_cnt, m_ones);
        end
    endtask

    task automatic test_prob_extremes();
        bit e;
        start_stream('0, 16'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0) ? 32'h0 : $urandom);
            n_checks++;
            if (bus.bit_valid !== 1'b1 || bus.bit_out !== 1'b0) begin
                n_errors++;
                $display("FAIL p0_bit cyc%0d got valid=%b bit=%b exp 1 0", i, bus.bit_valid, bus.bit_out);
            end
            void'(q_bits.pop_front());
        end
        n_checks++;
        if (bus.ones_cnt !== 16'd0 || bus.done !== 1'b1) begin
            n_errors++;
            $display("FAIL p0_ones got %0d done=%b exp 0 1", bus.ones_cnt, bus.done);
        end
        step(1'b0, 32'h0);
        // Largest PW-bit prob against the largest word top: strict compare gives 0
        start_stream(PROB_W'(17'h0FFFF), 16'd2);
        step(1'b1, 32'hFFFF_0000);
        n_checks++;
        if (bus.bit_out !== 1'b0 || bus.bit_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL pmax_ffff got bit=%b valid=%b exp 0 1", bus.bit_out, bus.bit_valid);
        end
        void'(q_bits.pop_front());
        step(1'b1, 32'hFFFE_FFFF);
        n_checks++;
        if (bus.bit_out !== 1'b1 || bus.ones_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL pmax_fffe got bit=%b ones=%0d exp 1 1", bus.bit_out, bus.ones_cnt);
        end
        void'(q_bits.pop_front());
        step(1'b0, 32'h0);
`ifdef SNG_FULLSCALE_EN
        start_stream(PROB_W'(17'h10000), 16'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0) ? 32'hFFFF_FFFF : $urandom);
            n_checks++;
            if (bus.bit_out !== 1'b1) begin
                n_errors++;
                $display("FAIL pfull_bit cyc%0d got %b exp 1", i, bus.bit_out);
            end
            void'(q_bits.pop_front());
        end
        n_checks++;
        if (bus.ones_cnt !== 16'd8) begin
            n_errors++;
            $display("FAIL pfull_ones got %0d exp 8", bus.ones_cnt);
        end
        step(1'b0, 32'h0);
`endif
    endtask

    task automatic test_start_ignored();
        logic [15:0] tops [4];
        bit e;
        tops = '{16'h1000, 16'h2000, 16'h9000, 16'h0001};
        start_stream(PROB_W'(17'h08000), 16'd4);
        bus.start = 1'b1;
        bus.prob  = '0;
        bus.len   = 16'd2;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, {tops[i], 16'h0});
            n_checks++;
            if (bus.bit_valid !== exp_valid) begin
                n_errors++;
                $display("FAIL ign_valid cyc%0d got %b exp %b", i, bus.bit_valid, exp_valid);
            end
            if (exp_valid) begin
                e = q_bits.pop_front();
                n_checks++;
                if (bus.bit_out !== e) begin
                    n_errors++;
                    $display("FAIL ign_bit cyc%0d got %b exp %b", i, bus.bit_out, e);
                end
            end
            n_checks++;
            if (bus.done !== exp_done) begin
                n_errors++;
                $display("FAIL ign_done cyc%0d got %b exp %b", i, bus.done, exp_done);
            end
        end
        n_checks++;
        if (bus.ones_cnt !== 16'd3) begin
            n_errors++;
            $display("FAIL ign_ones got %0d exp 3", bus.ones_cnt);
        end
        // start still high across the DONE edge must not launch a stream
        step(1'b1, 32'h0);
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL ign_in_done got busy=%b done=%b exp 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_async_reset();
        bit e;
        start_stream(PROB_W'(17'h0C000), 16'd10);
        step(1'b1, 32'h0000_0000);
        step(1'b1, 32'h1111_0000);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.rnd_ready, bus.bit_out, bus.bit_valid, bus.busy, bus.done} !== 5'b0 ||
            bus.ones_cnt !== '0) begin
            n_errors++;
            $display("FAIL arst_outputs got flags=%b ones=%0d exp 00000 0",
                     {bus.rnd_ready, bus.bit_out, bus.bit_valid, bus.busy, bus.done}, bus.ones_cnt);
        end
        q_bits.delete();
        m_run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_stream(PROB_W'(17'h06000), 16'd5);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, $urandom);
            n_checks++;
            if (bus.bit_valid !== exp_valid) begin
                n_errors++;
                $display("FAIL arst_valid cyc%0d got %b exp %b", i, bus.bit_valid, exp_valid);
            end
            if (exp_valid) begin
                e = q_bits.pop_front();
                n_checks++;
                if (bus.bit_out !== e) begin
                    n_errors++;
                    $display("FAIL arst_bit cyc%0d got %b exp %b", i, bus.bit_out, e);
                end
            end
            n_checks++;
            if (bus.done !== exp_done) begin
                n_errors++;
                $display("FAIL arst_done cyc%0d got %b exp %b", i, bus.done, exp_done);
            end
        end
        n_checks++;
        if (bus.ones_cnt !== 16'(m_ones)) begin
            n_errors++;
            $display("FAIL arst_ones got %0d exp %0d", bus.ones_cnt, m_ones);
        end
    endtask

    task automatic test_soak();
        logic [31:0] r;
        bit e;
        int bad;
        bad = 0;
        s1 = 32'h1234_5678;
        s2 = 32'h1234_5678;
        s3 = 32'h1234_5678;
        start_stream(PROB_W'(17'h04000), 16'd4096);
        for (int i = 0; i < 4096; i++) begin
            taus_step(r);
            step(1'b1, r);
            if (bus.bit_valid !== exp_valid) begin
                bad++;
            end else if (exp_valid) begin
                e = q_bits.pop_front();
                if (bus.bit_out !== e) bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL soak_bits got %0d bad cycles exp 0", bad);
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.ones_cnt !== 16'(m_ones)) begin
            n_errors++;
            $display("FAIL soak_final got done=%b ones=%0d exp 1 %0d", bus.done, bus.ones_cnt, m_ones);
        end
        n_checks++;
        if (bus.ones_cnt < 16'd928 || bus.ones_cnt > 16'd1120) begin
            n_errors++;
            $display("FAIL soak_range got %0d exp 928..1120", bus.ones_cnt);
        end
        step(1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_valid_gaps();
        test_prob_extremes();
        test_start_ignored();
        test_async_reset();
        test_soak();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
